cop_alzette_seq: RTL

Multi-cycle Alzette coprocessor on the core's `cop_*` coprocessor port. It computes the complete 4-step Alzette ARX-box, encrypt or decrypt, on (x=rs1, y=rs2) with one of 8 Sparkle round constants, and returns the x or y half. It is the parametrised successor of the single-cycle ISE decoder: steps-per-cycle is configurable, it has an IDLE/BUSY/DONE handshake with `cop_wait`, and an optional result cache lets the companion half return in one cycle.

---
 rtl/alzette_pkg.sv | 39 +++
 rtl/alzette_step.sv | 41 ++++
 rtl/cop_alzette_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alzette_pkg.sv
`default_nettype none
// ============================================================================
// Module : alzette_pkg
// Brief  : Alzette constants, rotation tables, instruction encodings, FSM
//          state type and rotate helper shared by the coprocessor files.
// Rev    : 1.0 - initial release
// ============================================================================
package alzette_pkg;

    // Sparkle round constants, element c at index c
    localparam logic [7:0][31:0] RCON = {
        32'hC2B3293D, 32'hCFBFA1C8, 32'h4F7C7B57, 32'hBB1185EB,
        32'h324E7738, 32'h38B4DA56, 32'hBF715880, 32'hB7E15162
    };

    // Per-step rotation amounts, step i at index i
    localparam logic [3:0][4:0] ROT_R = {5'd24, 5'd0,  5'd17, 5'd31};
    localparam logic [3:0][4:0] ROT_S = {5'd16, 5'd31, 5'd17, 5'd24};

    localparam logic [6:0] OPC_CUSTOM_2 = 7'b1011011;

    localparam logic [3:0] FN_ENC_X = 4'b1000;
    localparam logic [3:0] FN_ENC_Y = 4'b1001;
    localparam logic [3:0] FN_DEC_X = 4'b1010;
    localparam logic [3:0] FN_DEC_Y = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alz_state_e;

    // Shift by 32 yields zero, so n == 0 returns v unchanged
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        ror32 = (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alzette_step.sv
`default_nettype none
// ============================================================================
// Module : alzette_step
// Brief  : One combinational Alzette ARX step, encrypt or decrypt direction.
// Rev    : 1.0 - initial release
// ============================================================================
module alzette_step
    import alzette_pkg::*;
(
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic [31:0] i_rcon,
    input  logic [4:0]  i_r,
    input  logic [4:0]  i_s,
    input  logic        i_dec,
    output logic [31:0] o_x,
    output logic [31:0] o_y
);

    logic [31:0] w_xa;
    logic [31:0] w_yb;

    // Decrypt undoes the encrypt step in reverse order with the same (r, s)
    always_comb begin
        w_xa = '0;
        w_yb = '0;
        o_x  = '0;
        if (i_dec) begin
            w_xa = i_x ^ i_rcon;
            w_yb = i_y ^ ror32(w_xa, i_s);
            o_x  = w_xa - ror32(w_yb, i_r);
        end else begin
            w_xa = i_x + ror32(i_y, i_r);
            w_yb = i_y ^ ror32(w_xa, i_s);
            o_x  = w_xa ^ i_rcon;
        end
        o_y = w_yb;
    end

endmodule
`default_nettype wire

// File: rtl/cop_alzette_seq.sv
`default_nettype none
// ============================================================================
// Module : cop_alzette_seq
// Brief  : Multi-cycle Alzette coprocessor with IDLE/BUSY/DONE handshake.
//          Optional result cache enabled by defining ALZETTE_CACHE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module cop_alzette_seq
    import alzette_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        cop_clk,
    input  logic        cop_rst,
    input  logic        cop_valid,
    input  logic        cop_rdywr,
    input  logic [31:0] cop_insn,
    input  logic [31:0] cop_rs1,
    input  logic [31:0] cop_rs2,
    output logic        cop_ready,
    output logic        cop_wait,
    output logic        cop_wr,
    output logic [31:0] cop_rd
);

    localparam logic [1:0] C_CNT_INC  = 2'(STEPS_PER_CYCLE);
    localparam logic [1:0] C_LAST_CNT = 2'(4 - STEPS_PER_CYCLE);

    alz_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [2:0]  c_q, c_d;
    logic        dec_q, dec_d;
    logic        half_q, half_d;
    logic [31:0] rd_q, rd_d;

    logic        w_sel;
    logic        w_hit;
    logic        w_accept;
    logic        w_last;
    logic [2:0]  w_c;
    logic        w_dec;
    logic        w_half;
    logic [31:0] w_hit_rd;
    logic        w_unused;

    // funct[6:3] = 10xx covers all four ops: bit 1 picks dec, bit 0 picks y
    assign w_sel    = (cop_insn[6:0] == OPC_CUSTOM_2) && (cop_insn[31:30] == FN_ENC_X[3:2]);
    assign w_dec    = cop_insn[29];
    assign w_half   = cop_insn[28];
    assign w_c      = cop_insn[27:25];
    assign w_unused = ^cop_insn[24:7];

    assign w_accept = (state_q == ST_IDLE) && cop_valid && w_sel && !w_hit;
    assign w_last   = (state_q == ST_BUSY) && (cnt_q == C_LAST_CNT);

    logic [STEPS_PER_CYCLE:0][31:0] w_xc;
    logic [STEPS_PER_CYCLE:0][31:0] w_yc;

    assign w_xc[0] = x_q;
    assign w_yc[0] = y_q;

    // Decrypt walks steps 3..0, and 3 - pos equals ~pos on two bits
    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
        logic [1:0] w_pos;
        logic [1:0] w_idx;

        assign w_pos = cnt_q + 2'(k);
        assign w_idx = dec_q ? ~w_pos : w_pos;

        alzette_step u_step (
            .i_x    (w_xc[k]),
            .i_y    (w_yc[k]),
            .i_rcon (RCON[c_q]),
            .i_r    (ROT_R[w_idx]),
            .i_s    (ROT_S[w_idx]),
            .i_dec  (dec_q),
            .o_x    (w_xc[k+1]),
            .o_y    (w_yc[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        dec_d   = dec_q;
        half_d  = half_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    x_d     = cop_rs1;
                    y_d     = cop_rs2;
                    c_d     = w_c;
                    dec_d   = w_dec;
                    half_d  = w_half;
                end
            end
            ST_BUSY: begin
                x_d   = w_xc[STEPS_PER_CYCLE];
                y_d   = w_yc[STEPS_PER_CYCLE];
                cnt_d = cnt_q + C_CNT_INC;
                if (w_last) begin
                    rd_d    = half_q ? w_yc[STEPS_PER_CYCLE] : w_xc[STEPS_PER_CYCLE];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cop_rdywr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cop_clk or posedge cop_rst) begin
        if (cop_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            dec_q   <= 1'b0;
            half_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            dec_q   <= dec_d;
            half_q  <= half_d;
            rd_q    <= rd_d;
        end
    end

`ifdef ALZETTE_CACHE_EN
    logic        cvld_q, cvld_d;
    logic [31:0] tag_x_q, tag_x_d;
    logic [31:0] tag_y_q, tag_y_d;
    logic [2:0]  tag_c_q, tag_c_d;
    logic        tag_dec_q, tag_dec_d;
    logic [31:0] res_x_q, res_x_d;
    logic [31:0] res_y_q, res_y_d;

    // The tag is taken at accept since x_q/y_q are consumed by the computation
    always_comb begin
        cvld_d    = cvld_q;
        tag_x_d   = tag_x_q;
        tag_y_d   = tag_y_q;
        tag_c_d   = tag_c_q;
        tag_dec_d = tag_dec_q;
        res_x_d   = res_x_q;
        res_y_d   = res_y_q;
        if (w_accept) begin
            cvld_d    = 1'b0;
            tag_x_d   = cop_rs1;
            tag_y_d   = cop_rs2;
            tag_c_d   = w_c;
            tag_dec_d = w_dec;
        end
        if (w_last) begin
            cvld_d  = 1'b1;
            res_x_d = w_xc[STEPS_PER_CYCLE];
            res_y_d = w_yc[STEPS_PER_CYCLE];
        end
    end

    always_ff @(posedge cop_clk or posedge cop_rst) begin
        if (cop_rst) begin
            cvld_q    <= 1'b0;
            tag_x_q   <= '0;
            tag_y_q   <= '0;
            tag_c_q   <= '0;
            tag_dec_q <= 1'b0;
            res_x_q   <= '0;
            res_y_q   <= '0;
        end else begin
            cvld_q    <= cvld_d;
            tag_x_q   <= tag_x_d;
            tag_y_q   <= tag_y_d;
            tag_c_q   <= tag_c_d;
            tag_dec_q <= tag_dec_d;
            res_x_q   <= res_x_d;
            res_y_q   <= res_y_d;
        end
    end

    assign w_hit    = (state_q == ST_IDLE) && cop_valid && w_sel && cvld_q &&
                      (tag_x_q == cop_rs1) && (tag_y_q == cop_rs2) &&
                      (tag_c_q == w_c) && (tag_dec_q == w_dec);
    assign w_hit_rd = w_half ? res_y_q : res_x_q;
`else
    assign w_hit    = 1'b0;
    assign w_hit_rd = '0;
`endif

    // Outputs are forced to their reset values for as long as reset is held
    assign cop_wr    = !cop_rst && ((state_q == ST_DONE) || w_hit);
    assign cop_wait  = !cop_rst && ((state_q == ST_BUSY) ||
                       ((state_q == ST_IDLE) && cop_valid && w_sel && !w_hit));
    assign cop_ready = !(cop_wr && !cop_rdywr);
    assign cop_rd    = w_hit ? w_hit_rd : rd_q;

endmodule
`default_nettype wire
